video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Source-side video generator for the line-buffer path. It produces a raster stream of vsync, hsync, data-enable and 30-bit RGB from programmable timing inputs, and fills the active region with a selectable test pattern. It drives the video inputs of the line-buffer controller in simulation and bring-up, using the same timing-parameter convention.

Parameters:
CW, 8, width of the h/v counters and totals (worst-case total is 4*63 = 252)
FCW, 16, width of the frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_en  in  1  run request, sampled at frame boundaries only
i_pattern  in  2  pattern select, latched at frame start
VSW, VBP, VACT, VFP  in  6 each  vertical sync, back porch, active and front porch, in lines
HSW, HBP, HACT, HFP  in  6 each  horizontal sync, back porch, active and front porch, in clocks
o_vsync  out  1  active-high vertical sync
o_hsync  out  1  active-high horizontal sync
o_de  out  1  data enable
o_red, o_green, o_blue  out  10 each  pixel data
o_frame_done  out  1  one-cycle pulse on the last output cycle of each frame
o_frame_cnt  out  FCW  number of completed frames
o_err  out  1  timing inputs illegal while idle
o_busy  out  1  high while in ST_RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n), so it takes effect immediately, including mid-frame.
- Reset values: every output is 0; state = ST_IDLE; counters are 0.
- Totals: HTOT = HSW+HBP+HACT+HFP and VTOT = VSW+VBP+VACT+VFP, computed CW bits wide with no overflow.
- Legality: HSW, HACT, VSW and VACT must each be at least 1. Porches may be 0.
- States:
  - ST_IDLE: all video outputs are 0.
  - ST_RUN: frames are generated.
- ST_IDLE -> ST_RUN: on a clock edge with i_en=1 and legal timing inputs.
  - Latch all 8 timing inputs and i_pattern.
  - Set h_cnt = 0 and v_cnt = 0.
- If i_en=1 with illegal inputs in ST_IDLE: stay in ST_IDLE with o_err=1.
- o_err is combinational legality from the current inputs, qualified by ST_IDLE; it is 0 in ST_RUN.
- ST_RUN counting:
  - h_cnt increments every clock and wraps from HTOT-1 to 0.
  - On the h wrap, v_cnt increments and wraps from VTOT-1 to 0.
- Frame end: the cycle with h_cnt = HTOT-1 and v_cnt = VTOT-1.
  - o_frame_cnt increments on the output-aligned cycle after this (it wraps and is cleared only by reset).
  - If i_en=1: re-latch timing and pattern and continue seamlessly, with no idle gap.
  - If i_en=0: go to ST_IDLE.
- Changes to timing inputs or i_pattern mid-frame have no effect until the next frame start.
- Decode uses the latched values:
  - hsync when h_cnt < HSW.
  - vsync when v_cnt < VSW, covering whole lines including all h positions.
  - de when HSW+HBP <= h_cnt < HSW+HBP+HACT and VSW+VBP <= v_cnt < VSW+VBP+VACT.
- Output latency: all outputs are registered, one cycle after the counter value they decode.
  - The first o_vsync=o_hsync=1 cycle appears on the 2nd rising edge after i_en is first sampled high in ST_IDLE.
- o_frame_done is registered and coincides with the output of the frame-end position.
- o_busy is registered and aligned with the video outputs, so it stays high through the final output cycle of the last frame.
- Pixel coordinates: x = h_cnt-(HSW+HBP) and y = v_cnt-(VSW+VBP), each CW bits. They are valid only while de.
- Pattern (data is 0 whenever de=0):
  - 0: red = {2'b0, x}, green = {2'b0, y}, blue = o_frame_cnt[9:0].
  - 1: checker; all channels 10'h3FF if x[0]^y[0], else 0.
  - 2: all channels 10'h3FF.
  - 3: red = o_frame_cnt[9:0], green = 0, blue = 10'h3FF.
- Back-to-back frames: the final cycle of frame N and the first cycle of frame N+1 are on consecutive outputs.
- Reset mid-frame: outputs drop to 0 at once. After release, the block waits in ST_IDLE for i_en.

Test Plan:
1. Timing VSW=1 VBP=1 VACT=4 VFP=1, HSW=2 HBP=6 HACT=3 HFP=13, pattern 0, i_en held 1.
   - Expect HTOT=24 and VTOT=7, so 168 cycles per frame.
   - Per line: hsync is 2 cycles, and de is 3 cycles starting at line offset 8.
   - vsync is high for exactly the first 24 cycles of each frame.
   - There are 4 de lines per frame.
   - o_frame_done pulses every 168 cycles.
2. Same timing, pattern 0, frame 0.
   - de pixels are red = 0,1,2 per line, green = 0..3 across lines, blue = 0.
   - In frame 1, blue = 1 and o_frame_cnt = 1.
3. Raise i_en, then drop it at cycle 50 of frame 0.
   - Frame 0 completes all 168 cycles.
   - o_busy falls after the frame_done cycle, and all outputs are 0 thereafter.
4. Change HACT from 3 to 5 mid-frame.
   - The current frame keeps 3-pixel de.
   - The next frame has 5-pixel de and HTOT=26.
5. Set HACT=0 with i_en=1.
   - o_err=1, o_busy stays 0 and no sync is emitted.
   - Then set HACT=3: the first hsync appears 2 edges later.
6. Assert rst_n low at cycle 100 of frame 1, pattern 1.
   - All outputs are 0 immediately and o_frame_cnt = 0.
   - After release with i_en=1, the checker restarts at frame 0 with the pixel (0,0) value = 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Source-side raster generator for the line-buffer path. Produces vsync,
// hsync, data-enable and 30-bit RGB from programmable timing, and fills the
// active region with one of four test patterns. All eight timing inputs and
// the pattern select are captured at each frame start, so the upstream
// control logic may change them freely mid-frame.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_en           run request, only looked at on frame boundaries
//   i_pattern      pattern select (0 ramp, 1 checker, 2 white, 3 frame colour)
//   VSW/VBP/VACT/VFP  vertical sync, back porch, active, front porch (lines)
//   HSW/HBP/HACT/HFP  horizontal sync, back porch, active, front porch (clocks)
//   o_vsync        active-high vertical sync
//   o_hsync        active-high horizontal sync
//   o_de           data enable
//   o_red/green/blue  10-bit pixel channels, zero outside the active region
//   o_frame_done   one-cycle pulse on the last output cycle of a frame
//   o_frame_cnt    count of completed frames (wraps, cleared by reset only)
//   o_err          current timing inputs illegal while idle
//   o_busy         high while generating, aligned with the video outputs
// ---------------------------------------------------------------------------
module video_timing_gen #(
   parameter int CW  = 8,
   parameter int FCW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_en,
   input  logic [1:0]     i_pattern,
   input  logic [5:0]     VSW,
   input  logic [5:0]     VBP,
   input  logic [5:0]     VACT,
   input  logic [5:0]     VFP,
   input  logic [5:0]     HSW,
   input  logic [5:0]     HBP,
   input  logic [5:0]     HACT,
   input  logic [5:0]     HFP,
   output logic           o_vsync,
   output logic           o_hsync,
   output logic           o_de,
   output logic [9:0]     o_red,
   output logic [9:0]     o_green,
   output logic [9:0]     o_blue,
   output logic           o_frame_done,
   output logic [FCW-1:0] o_frame_cnt,
   output logic           o_err,
   output logic           o_busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_hCnt;
   logic [CW-1:0] r_vCnt;

   // Timing captured at frame start
   logic [5:0]    r_vsw;
   logic [5:0]    r_vbp;
   logic [5:0]    r_vact;
   logic [5:0]    r_vfp;
   logic [5:0]    r_hsw;
   logic [5:0]    r_hbp;
   logic [5:0]    r_hact;
   logic [5:0]    r_hfp;
   logic [1:0]    r_pattern;

   logic          w_legal;
   logic          w_launch;
   logic          w_run;
   logic          w_hLast;
   logic          w_vLast;
   logic          w_frameEnd;
   logic          w_load;

   logic [CW-1:0] w_hTot;
   logic [CW-1:0] w_vTot;
   logic [CW-1:0] w_hActStart;
   logic [CW-1:0] w_hActStop;
   logic [CW-1:0] w_vActStart;
   logic [CW-1:0] w_vActStop;

   logic          w_hsync;
   logic          w_vsync;
   logic          w_de;
   logic [CW-1:0] w_x;
   logic [CW-1:0] w_y;
   logic [9:0]    w_fcnt10;
   logic [9:0]    w_red;
   logic [9:0]    w_green;
   logic [9:0]    w_blue;

   // Sync and active widths must be non-zero; porches may be empty.
   assign w_legal  = (HSW != 6'd0) && (HACT != 6'd0) &&
                     (VSW != 6'd0) && (VACT != 6'd0);
   assign w_launch = i_en && w_legal;
   assign w_run    = (r_state == ST_RUN);

   // Totals and active window edges, all from the captured timing. Each
   // field is at most 63, so four of them fit in CW bits without overflow.
   assign w_hTot      = CW'(r_hsw) + CW'(r_hbp) + CW'(r_hact) + CW'(r_hfp);
   assign w_vTot      = CW'(r_vsw) + CW'(r_vbp) + CW'(r_vact) + CW'(r_vfp);
   assign w_hActStart = CW'(r_hsw) + CW'(r_hbp);
   assign w_hActStop  = w_hActStart + CW'(r_hact);
   assign w_vActStart = CW'(r_vsw) + CW'(r_vbp);
   assign w_vActStop  = w_vActStart + CW'(r_vact);

   assign w_hLast    = (r_hCnt == (w_hTot - CW'(1)));
   assign w_vLast    = (r_vCnt == (w_vTot - CW'(1)));
   assign w_frameEnd = w_run && w_hLast && w_vLast;

   // Timing is (re)captured when leaving idle and at every frame end that
   // continues straight into another frame, so back-to-back frames need
   // no idle gap.
   assign w_load = w_launch && ((r_state == ST_IDLE) || w_frameEnd);

   // Legality flag is only meaningful while waiting to start; it is held
   // low during reset so every output reads 0 then.
   assign o_err = rst_n && (r_state == ST_IDLE) && !w_legal;

   // State and raster counters. The h counter runs every clock while
   // running and wraps at HTOT-1; the v counter steps on each h wrap. At the
   // frame end both return to 0 and the block either continues or idles
   // depending on i_en and the legality of the inputs at that moment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hCnt  <= '0;
         r_vCnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_hCnt <= '0;
               r_vCnt <= '0;
               if (w_launch) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_frameEnd) begin
                  r_hCnt <= '0;
                  r_vCnt <= '0;
                  if (!w_launch) begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_hLast) begin
                  r_hCnt <= '0;
                  r_vCnt <= r_vCnt + CW'(1);
               end else begin
                  r_hCnt <= r_hCnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hCnt  <= '0;
               r_vCnt  <= '0;
            end
         endcase
      end
   end

   // Capture of timing and pattern. Mid-frame input changes are ignored
   // until the next frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsw     <= '0;
         r_vbp     <= '0;
         r_vact    <= '0;
         r_vfp     <= '0;
         r_hsw     <= '0;
         r_hbp     <= '0;
         r_hact    <= '0;
         r_hfp     <= '0;
         r_pattern <= '0;
      end else if (w_load) begin
         r_vsw     <= VSW;
         r_vbp     <= VBP;
         r_vact    <= VACT;
         r_vfp     <= VFP;
         r_hsw     <= HSW;
         r_hbp     <= HBP;
         r_hact    <= HACT;
         r_hfp     <= HFP;
         r_pattern <= i_pattern;
      end
   end

   assign w_fcnt10 = 10'(o_frame_cnt);

   // Raster decode and pattern generation from the current counter
   // position. The frame-count based patterns read the output register
   // directly; because the first line is always a sync line it has already
   // advanced by the time any active pixel of the new frame is decoded.
   always_comb begin
      w_hsync = 1'b0;
      w_vsync = 1'b0;
      w_de    = 1'b0;
      w_x     = r_hCnt - w_hActStart;
      w_y     = r_vCnt - w_vActStart;
      w_red   = 10'd0;
      w_green = 10'd0;
      w_blue  = 10'd0;
      if (w_run) begin
         w_hsync = (r_hCnt < CW'(r_hsw));
         w_vsync = (r_vCnt < CW'(r_vsw));
         w_de    = (r_hCnt >= w_hActStart) && (r_hCnt < w_hActStop) &&
                   (r_vCnt >= w_vActStart) && (r_vCnt < w_vActStop);
      end
      if (w_de) begin
         case (r_pattern)
            2'd0: begin
               w_red   = 10'(w_x);
               w_green = 10'(w_y);
               w_blue  = w_fcnt10;
            end
            2'd1: begin
               if (w_x[0] ^ w_y[0]) begin
                  w_red   = 10'h3FF;
                  w_green = 10'h3FF;
                  w_blue  = 10'h3FF;
               end
            end
            2'd2: begin
               w_red   = 10'h3FF;
               w_green = 10'h3FF;
               w_blue  = 10'h3FF;
            end
            default: begin
               w_red   = w_fcnt10;
               w_green = 10'd0;
               w_blue  = 10'h3FF;
            end
         endcase
      end
   end

   // Output registers, one cycle behind the counter position they decode.
   // The frame counter steps on the cycle after the frame_done pulse so
   // that it reads as the new count from the first output of the next
   // frame onward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vsync      <= 1'b0;
         o_hsync      <= 1'b0;
         o_de         <= 1'b0;
         o_red        <= '0;
         o_green      <= '0;
         o_blue       <= '0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= '0;
         o_busy       <= 1'b0;
      end else begin
         o_vsync      <= w_vsync;
         o_hsync      <= w_hsync;
         o_de         <= w_de;
         o_red        <= w_red;
         o_green      <= w_green;
         o_blue       <= w_blue;
         o_frame_done <= w_frameEnd;
         o_busy       <= w_run;
         if (o_frame_done) begin
            o_frame_cnt <= o_frame_cnt + FCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Testbench for video_timing_gen. A reference model describes each frame as
// a linear cycle index k = v*HTOT + h over the captured timing and derives
// every output from that index with plain arithmetic. Directed phases walk
// through the bring-up scenarios, then a randomized phase perturbs timing,
// pattern, enable and reset.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_en = 1'b0;
   logic [1:0]  i_pattern = 2'd0;
   logic [5:0]  VSW = 6'd1, VBP = 6'd1, VACT = 6'd4, VFP = 6'd1;
   logic [5:0]  HSW = 6'd2, HBP = 6'd6, HACT = 6'd3, HFP = 6'd13;

   logic        o_vsync, o_hsync, o_de, o_frame_done, o_err, o_busy;
   logic [9:0]  o_red, o_green, o_blue;
   logic [15:0] o_frame_cnt;

   int checkCount = 0;
   int failCount  = 0;

   int cntDe, cntVs, cntHs, cntDone, cntBusy;
   bit randomMode = 1'b0;

   video_timing_gen #(.CW(8), .FCW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (i_en),
      .i_pattern    (i_pattern),
      .VSW          (VSW),
      .VBP          (VBP),
      .VACT         (VACT),
      .VFP          (VFP),
      .HSW          (HSW),
      .HBP          (HBP),
      .HACT         (HACT),
      .HFP          (HFP),
      .o_vsync      (o_vsync),
      .o_hsync      (o_hsync),
      .o_de         (o_de),
      .o_red        (o_red),
      .o_green      (o_green),
      .o_blue       (o_blue),
      .o_frame_done (o_frame_done),
      .o_frame_cnt  (o_frame_cnt),
      .o_err        (o_err),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          mRun = 1'b0;
   int          mK = 0;
   int          mHsw, mHbp, mHact, mHfp, mVsw, mVbp, mVact, mVfp, mPat;
   logic        eVs = 1'b0, eHs = 1'b0, eDe = 1'b0, eDone = 1'b0, eBusy = 1'b0;
   logic [9:0]  eR = '0, eG = '0, eB = '0;
   logic [15:0] eFcnt = '0;

   function automatic bit legalIn();
      return (HSW != 0) && (HACT != 0) && (VSW != 0) && (VACT != 0);
   endfunction

   // Reference model: the output of the current frame index appears one
   // clock later; a frame is HTOT*VTOT cycles long.
   always @(posedge clk or negedge rst_n) begin : refModel
      int htot, vtot, h, v, x, y, last;
      bit inH, inV;
      if (!rst_n) begin
         mRun  <= 1'b0;
         mK    <= 0;
         eVs   <= 1'b0;
         eHs   <= 1'b0;
         eDe   <= 1'b0;
         eDone <= 1'b0;
         eBusy <= 1'b0;
         eR    <= '0;
         eG    <= '0;
         eB    <= '0;
         eFcnt <= '0;
      end else begin
         eBusy <= mRun;
         if (eDone) eFcnt <= eFcnt + 16'd1;
         if (mRun) begin
            htot = mHsw + mHbp + mHact + mHfp;
            vtot = mVsw + mVbp + mVact + mVfp;
            last = htot * vtot - 1;
            h    = mK % htot;
            v    = mK / htot;
            inH  = (h >= mHsw + mHbp) && (h < mHsw + mHbp + mHact);
            inV  = (v >= mVsw + mVbp) && (v < mVsw + mVbp + mVact);
            x    = (h - mHsw - mHbp) & 255;
            y    = (v - mVsw - mVbp) & 255;
            eHs   <= (h < mHsw);
            eVs   <= (v < mVsw);
            eDe   <= inH && inV;
            eDone <= (mK == last);
            if (inH && inV) begin
               case (mPat)
                  0: begin eR <= 10'(x); eG <= 10'(y); eB <= eFcnt[9:0]; end
                  1: begin
                     eR <= ((x ^ y) & 1) != 0 ? 10'h3FF : 10'h0;
                     eG <= ((x ^ y) & 1) != 0 ? 10'h3FF : 10'h0;
                     eB <= ((x ^ y) & 1) != 0 ? 10'h3FF : 10'h0;
                  end
                  2: begin eR <= 10'h3FF; eG <= 10'h3FF; eB <= 10'h3FF; end
                  default: begin eR <= eFcnt[9:0]; eG <= 10'h0; eB <= 10'h3FF; end
               endcase
            end else begin
               eR <= '0; eG <= '0; eB <= '0;
            end
            if (mK == last) begin
               mK <= 0;
               if (i_en && legalIn()) begin
                  mHsw <= HSW; mHbp <= HBP; mHact <= HACT; mHfp <= HFP;
                  mVsw <= VSW; mVbp <= VBP; mVact <= VACT; mVfp <= VFP;
                  mPat <= i_pattern;
               end else begin
                  mRun <= 1'b0;
               end
            end else begin
               mK <= mK + 1;
            end
         end else begin
            eHs <= 1'b0; eVs <= 1'b0; eDe <= 1'b0; eDone <= 1'b0;
            eR <= '0; eG <= '0; eB <= '0;
            if (i_en && legalIn()) begin
               mHsw <= HSW; mHbp <= HBP; mHact <= HACT; mHfp <= HFP;
               mVsw <= VSW; mVbp <= VBP; mVact <= VACT; mVfp <= VFP;
               mPat <= i_pattern;
               mK   <= 0;
               mRun <= 1'b1;
            end
         end
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("vsync", 32'(o_vsync), 32'(eVs));
      checkOutput("hsync", 32'(o_hsync), 32'(eHs));
      checkOutput("de", 32'(o_de), 32'(eDe));
      checkOutput("red", 32'(o_red), 32'(eR));
      checkOutput("green", 32'(o_green), 32'(eG));
      checkOutput("blue", 32'(o_blue), 32'(eB));
      checkOutput("frame_done", 32'(o_frame_done), 32'(eDone));
      checkOutput("frame_cnt", 32'(o_frame_cnt), 32'(eFcnt));
      checkOutput("busy", 32'(o_busy), 32'(eBusy));
      checkOutput("err", 32'(o_err), 32'(rst_n && !mRun && !legalIn()));
   endtask

   task automatic randTiming();
      VSW  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
      VACT = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
      HSW  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
      HACT = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
      VBP  = 6'($urandom_range(0, 6));
      VFP  = 6'($urandom_range(0, 6));
      HBP  = 6'($urandom_range(0, 6));
      HFP  = 6'($urandom_range(0, 6));
   endtask

   // Advance n cycles; compare on each falling edge, then optionally
   // perturb the inputs while still away from the rising edge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         compareAll();
         cntDe   += int'(o_de);
         cntVs   += int'(o_vsync);
         cntHs   += int'(o_hsync);
         cntDone += int'(o_frame_done);
         cntBusy += int'(o_busy);
         if (randomMode) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 149) == 0) i_en = ~i_en;
            if ($urandom_range(0, 99) == 0) i_pattern = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) randTiming();
         end
      end
   endtask

   task automatic clearCounts();
      cntDe = 0; cntVs = 0; cntHs = 0; cntDone = 0; cntBusy = 0;
   endtask

   initial begin
      clearCounts();
      // Reset state
      applyStimulus(3);
      checkOutput("reset_busy", 32'(o_busy), 32'd0);
      checkOutput("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);

      // Base timing, pattern 0, enable held high: HTOT=24, VTOT=7
      rst_n = 1'b1;
      i_en  = 1'b1;
      applyStimulus(1);
      clearCounts();
      applyStimulus(168);
      checkOutput("f0_de_count", 32'(cntDe), 32'd12);
      checkOutput("f0_vsync_count", 32'(cntVs), 32'd24);
      checkOutput("f0_hsync_count", 32'(cntHs), 32'd14);
      checkOutput("f0_done_count", 32'(cntDone), 32'd1);
      clearCounts();
      applyStimulus(1);
      checkOutput("f1_frame_cnt", 32'(o_frame_cnt), 32'd1);
      applyStimulus(56);
      checkOutput("f1_first_de", 32'(o_de), 32'd1);
      checkOutput("f1_first_blue", 32'(o_blue), 32'd1);
      checkOutput("f1_first_red", 32'(o_red), 32'd0);
      applyStimulus(111);
      checkOutput("f1_de_count", 32'(cntDe), 32'd12);
      checkOutput("f1_done_count", 32'(cntDone), 32'd1);
      i_en = 1'b0;
      applyStimulus(200);

      // Enable dropped at cycle 50: the frame still completes
      i_en = 1'b1;
      applyStimulus(1);
      clearCounts();
      applyStimulus(50);
      i_en = 1'b0;
      applyStimulus(200);
      checkOutput("drop_busy_count", 32'(cntBusy), 32'd168);
      checkOutput("drop_done_count", 32'(cntDone), 32'd1);
      checkOutput("drop_de_count", 32'(cntDe), 32'd12);
      checkOutput("drop_idle_busy", 32'(o_busy), 32'd0);

      // HACT changed mid-frame takes effect from the next frame
      i_en = 1'b1;
      applyStimulus(1);
      clearCounts();
      for (int i = 0; i < 168; i++) begin
         if (i == 60) HACT = 6'd5;
         applyStimulus(1);
      end
      checkOutput("hact3_de_count", 32'(cntDe), 32'd12);
      checkOutput("hact3_done_count", 32'(cntDone), 32'd1);
      clearCounts();
      applyStimulus(182);
      checkOutput("hact5_de_count", 32'(cntDe), 32'd20);
      checkOutput("hact5_done_count", 32'(cntDone), 32'd1);
      i_en = 1'b0;
      applyStimulus(300);

      // Illegal HACT while idle, then legal: sync two edges later
      HACT = 6'd0;
      i_en = 1'b1;
      applyStimulus(1);
      checkOutput("illegal_err", 32'(o_err), 32'd1);
      clearCounts();
      applyStimulus(20);
      checkOutput("illegal_hsync_count", 32'(cntHs), 32'd0);
      checkOutput("illegal_busy_count", 32'(cntBusy), 32'd0);
      HACT = 6'd3;
      applyStimulus(1);
      checkOutput("legal_hsync_edge1", 32'(o_hsync), 32'd0);
      applyStimulus(1);
      checkOutput("legal_hsync_edge2", 32'(o_hsync), 32'd1);
      checkOutput("legal_vsync_edge2", 32'(o_vsync), 32'd1);
      i_en = 1'b0;
      applyStimulus(300);

      // Reset at cycle 100 of frame 1 with the checker pattern
      i_pattern = 2'd1;
      i_en = 1'b1;
      applyStimulus(1 + 168 + 100);
      rst_n = 1'b0;
      #1;
      compareAll();
      checkOutput("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      applyStimulus(3);
      rst_n = 1'b1;
      applyStimulus(58);
      checkOutput("rst_pixel00_de", 32'(o_de), 32'd1);
      checkOutput("rst_pixel00_red", 32'(o_red), 32'd0);
      applyStimulus(1);
      checkOutput("rst_pixel10_red", 32'(o_red), 32'h3FF);
      i_en = 1'b0;
      applyStimulus(300);

      // Randomized timing, pattern, enable and reset
      randomMode = 1'b1;
      for (int r = 0; r < 30; r++) begin
         randTiming();
         i_pattern = 2'($urandom_range(0, 3));
         i_en = 1'b1;
         applyStimulus(500);
      end
      randomMode = 1'b0;
      rst_n = 1'b1;
      i_en  = 1'b0;
      applyStimulus(700);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
